// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline slot with load-data formatting and register file writeback.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int PC_BITS      = 32,
    parameter int PC_ADDR_SIZE = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    halt,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_reg_write,
    input  logic                    in_mem_to_reg,
    input  logic [2:0]              in_load_type,
    input  logic [PC_ADDR_SIZE-1:0] in_dest,
    input  logic [PC_BITS-1:0]      in_alu_result,
    input  logic [PC_BITS-1:0]      in_mem_rdata,
    output logic [PC_ADDR_SIZE-1:0] write_adress,
    output logic [PC_BITS-1:0]      write_data,
    output logic                    write_enable,
    output logic                    fwd_valid,
    output logic [PC_ADDR_SIZE-1:0] fwd_addr,
    output logic [PC_BITS-1:0]      fwd_data,
    output logic                    align_err,
    output logic [31:0]             retire_count
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic                    valid_q;
    logic                    reg_write_q;
    logic                    mem_to_reg_q;
    logic [2:0]              load_type_q;
    logic [PC_ADDR_SIZE-1:0] dest_q;
    logic [PC_BITS-1:0]      alu_q;
    logic [PC_BITS-1:0]      rdata_q;

    logic [1:0]         off;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [PC_BITS-1:0] load_data;
    logic [PC_BITS-1:0] wb_data;
    logic               live;
    logic               is_half;
    logic               is_word;

    assign in_ready = ~halt;

    // Payload fields only load on a real capture; the valid bit alone marks bubbles and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            load_type_q  <= 3'b000;
            dest_q       <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
        end else if (!halt) begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (in_valid) begin
                valid_q      <= 1'b1;
                reg_write_q  <= in_reg_write;
                mem_to_reg_q <= in_mem_to_reg;
                load_type_q  <= in_load_type;
                dest_q       <= in_dest;
                alu_q        <= in_alu_result;
                rdata_q      <= in_mem_rdata;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        off      = alu_q[1:0];
        byte_sel = rdata_q[7:0];
        case (off)
            2'd0: byte_sel = rdata_q[7:0];
            2'd1: byte_sel = rdata_q[15:8];
            2'd2: byte_sel = rdata_q[23:16];
            2'd3: byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
        half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];

        load_data = rdata_q;
        case (load_type_q)
            LT_LB:   load_data = {{(PC_BITS-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {{(PC_BITS-8){1'b0}}, byte_sel};
            LT_LH:   load_data = {{(PC_BITS-16){half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {{(PC_BITS-16){1'b0}}, half_sel};
            default: load_data = rdata_q;
        endcase

        wb_data = mem_to_reg_q ? load_data : alu_q;
    end

    // Unknown load encodings behave as LW, including for the alignment check.
    assign is_half = (load_type_q == LT_LH) || (load_type_q == LT_LHU);
    assign is_word = !is_half && (load_type_q != LT_LB) && (load_type_q != LT_LBU);

    assign live = valid_q & reg_write_q & (dest_q != '0);

    assign write_enable = live & ~halt;
    assign write_adress = dest_q;
    assign write_data   = wb_data;
    assign fwd_valid    = live;
    assign fwd_addr     = dest_q;
    assign fwd_data     = wb_data;
    assign align_err    = valid_q & mem_to_reg_q &
                          ((is_word & (off != 2'd0)) | (is_half & off[0]));

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Every valid slot leaving the stage counts, whether or not it writes a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= 32'd0;
        end else if (valid_q && !halt) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, corner sequences,
// and randomized traffic against a slot-level reference model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [2:0]  in_load_type;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [4:0]  write_adress;
    logic [31:0] write_data;
    logic        write_enable;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        align_err;
    logic [31:0] retire_count;

    mem_wb_stage #(.PC_BITS(32), .PC_ADDR_SIZE(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg_write (in_reg_write),
        .in_mem_to_reg(in_mem_to_reg),
        .in_load_type (in_load_type),
        .in_dest      (in_dest),
        .in_alu_result(in_alu_result),
        .in_mem_rdata (in_mem_rdata),
        .write_adress (write_adress),
        .write_data   (write_data),
        .write_enable (write_enable),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .align_err    (align_err),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instruction currently sitting in writeback.
    logic        m_valid;
    logic        m_rw;
    logic        m_m2r;
    logic [2:0]  m_lt;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic [31:0] m_count;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [2:0]  lt;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_align;
    } vec_t;

    vec_t vecs[9];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelData();
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = m_alu % 4;
        if (!m_m2r) return m_alu;
        b = (m_rdata >> (8 * off)) & 32'hFF;
        h = (m_rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (m_lt)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return m_rdata;
        endcase
    endfunction

    function automatic logic modelAlign();
        int unsigned off;
        off = m_alu % 4;
        if (!(m_valid && m_m2r)) return 1'b0;
        if (m_lt == 3'd3 || m_lt == 3'd4) return (off % 2) == 1;
        if (m_lt == 3'd1 || m_lt == 3'd2) return 1'b0;
        return off != 0;
    endfunction

    function automatic logic modelLive();
        return m_valid && m_rw && (m_dest != 5'd0);
    endfunction

    task automatic modelReset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = 0;
        m_dest = 0; m_alu = 0; m_rdata = 0; m_count = 0;
    endtask

    task automatic checkOutput(input string tag);
        logic live;
        live = modelLive();
        checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(!halt));
        checkVal({tag, ".write_enable"}, 32'(write_enable), 32'(live && !halt));
        checkVal({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(live));
        checkVal({tag, ".align_err"}, 32'(align_err), 32'(modelAlign()));
`ifdef WB_RETIRE_CNT_EN
        checkVal({tag, ".retire_count"}, retire_count, m_count);
`else
        checkVal({tag, ".retire_count"}, retire_count, 32'd0);
`endif
        if (m_valid) begin
            checkVal({tag, ".write_adress"}, 32'(write_adress), 32'(m_dest));
            checkVal({tag, ".fwd_addr"}, 32'(fwd_addr), 32'(m_dest));
            checkVal({tag, ".write_data"}, write_data, modelData());
            checkVal({tag, ".fwd_data"}, fwd_data, modelData());
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check.
    task automatic applyStimulus(input string tag, input logic v, input logic h, input logic f,
                                 input logic rw, input logic m2r, input logic [2:0] lt,
                                 input logic [4:0] dest, input logic [31:0] alu,
                                 input logic [31:0] rdata);
        in_valid = v; halt = h; flush = f;
        in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
        in_dest = dest; in_alu_result = alu; in_mem_rdata = rdata;
        @(posedge clk);
        if (!h) begin
            if (m_valid) m_count = m_count + 32'd1;
            if (f) m_valid = 0;
            else if (v) begin
                m_valid = 1; m_rw = rw; m_m2r = m2r; m_lt = lt;
                m_dest = dest; m_alu = alu; m_rdata = rdata;
            end else m_valid = 0;
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, ".write_enable"}, 32'(write_enable), 32'd0);
        checkVal({tag, ".write_data"}, write_data, 32'd0);
        checkVal({tag, ".write_adress"}, 32'(write_adress), 32'd0);
        checkVal({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
        checkVal({tag, ".fwd_addr"}, 32'(fwd_addr), 32'd0);
        checkVal({tag, ".fwd_data"}, fwd_data, 32'd0);
        checkVal({tag, ".align_err"}, 32'(align_err), 32'd0);
        checkVal({tag, ".retire_count"}, retire_count, 32'd0);
        checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(!halt));
    endtask

    initial begin
        vecs[0] = '{1, 0, 3'd0, 5'd8, 32'h1234_5678, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0};
        vecs[1] = '{1, 1, 3'd1, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 1, 32'hFFFF_FF80, 0};
        vecs[2] = '{1, 1, 3'd2, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 1, 32'h0000_0080, 0};
        vecs[3] = '{1, 1, 3'd3, 5'd4, 32'h0000_2002, 32'h8001_0000, 1, 32'hFFFF_8001, 0};
        vecs[4] = '{1, 1, 3'd4, 5'd4, 32'h0000_2001, 32'h8001_0000, 1, 32'h0000_0000, 1};
        vecs[5] = '{1, 1, 3'd0, 5'd7, 32'h0000_4002, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1};
        vecs[6] = '{1, 1, 3'd1, 5'd9, 32'h0000_0001, 32'h80FF_7F01, 1, 32'h0000_007F, 0};
        vecs[7] = '{1, 0, 3'd0, 5'd0, 32'h0000_0005, 32'h0000_0000, 0, 32'h0000_0005, 0};
        vecs[8] = '{0, 0, 3'd0, 5'd4, 32'h0000_0006, 32'h0000_0000, 0, 32'h0000_0006, 0};

        rst_n = 0; halt = 0; flush = 0; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_load_type = 0; in_dest = 0; in_alu_result = 0; in_mem_rdata = 0;
        modelReset();
        #12;
        checkResetState("reset");
        halt = 1; #1;
        checkVal("reset.in_ready_halt", 32'(in_ready), 32'd0);
        halt = 0;
        @(negedge clk);
        rst_n = 1;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), 1, 0, 0, vecs[i].rw, vecs[i].m2r, vecs[i].lt,
                          vecs[i].dest, vecs[i].alu, vecs[i].rdata);
            checkVal($sformatf("vec%0d.we", i), 32'(write_enable), 32'(vecs[i].exp_we));
            checkVal($sformatf("vec%0d.align", i), 32'(align_err), 32'(vecs[i].exp_align));
            checkVal($sformatf("vec%0d.data", i), write_data, vecs[i].exp_data);
            if (vecs[i].exp_we) checkVal($sformatf("vec%0d.addr", i), 32'(write_adress), 32'(vecs[i].dest));
        end
        idle("vec.drain");

        $display("[TB] halt sequence");
        applyStimulus("halt.load", 1, 0, 0, 1, 0, 3'd0, 5'd5, 32'hA5A5_0001, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("halt%0d", i), 1, 1, 0, 1, 0, 3'd0, 5'd6, 32'h0BAD_0BAD, 32'd0);
            checkVal($sformatf("halt%0d.fwd_data", i), fwd_data, 32'hA5A5_0001);
            checkVal($sformatf("halt%0d.fwd_addr", i), 32'(fwd_addr), 32'd5);
        end
        halt = 0; in_valid = 0; #1;
        checkOutput("halt.release");
        checkVal("halt.release.we", 32'(write_enable), 32'd1);
        idle("halt.drain");

        $display("[TB] flush and halt+flush");
        applyStimulus("flush.load", 1, 0, 0, 1, 0, 3'd0, 5'd10, 32'h1111_2222, 32'd0);
        applyStimulus("flush.both", 1, 1, 1, 1, 0, 3'd0, 5'd11, 32'h3333_4444, 32'd0);
        checkVal("flush.both.fwd_valid", 32'(fwd_valid), 32'd1);
        applyStimulus("flush.drop", 1, 0, 1, 1, 0, 3'd0, 5'd12, 32'h5555_6666, 32'd0);
        checkVal("flush.drop.we", 32'(write_enable), 32'd0);

        $display("[TB] reset mid-instruction");
        applyStimulus("rst.load", 1, 0, 0, 1, 1, 3'd3, 5'd13, 32'h0000_0003, 32'hFFFF_FFFF);
        applyStimulus("rst.load2", 1, 0, 0, 1, 0, 3'd0, 5'd14, 32'h7777_8888, 32'd0);
        #2;
        rst_n = 0;
        #1;
        checkResetState("rst.mid");
        modelReset();
        @(negedge clk);
        rst_n = 1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus($sformatf("rnd%0d", i),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 4) != 0,
                          1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)),
                          d, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
